// File: rtl/tmds_decode.sv
// tmds_decode: one TMDS receive channel; finds the word boundary and decodes pixel/control words.
module tmds_decode #(
   parameter int CTKN_CNT     = 8,
   parameter int SEARCH_WIN   = 1024,
   parameter int SLIP_WAIT    = 8,
   parameter int LOCK_TIMEOUT = 8192
) (
   input  logic       clkin,
   input  logic       rstin,
   input  logic [9:0] din,
   output logic       bitslip,
   output logic       aligned,
   output logic       lock_lost,
   output logic [7:0] dout,
   output logic       de,
   output logic       c0,
   output logic       c1
);
   localparam int TW = CTKN_CNT > 1 ? $clog2(CTKN_CNT) : 1;
   localparam int WW = SEARCH_WIN > 1 ? $clog2(SEARCH_WIN) : 1;
   localparam int SW = SLIP_WAIT > 1 ? $clog2(SLIP_WAIT) : 1;
   localparam int IW = LOCK_TIMEOUT > 1 ? $clog2(LOCK_TIMEOUT) : 1;

   typedef enum logic [1:0] {ST_SEARCH, ST_SLIP_WAIT, ST_LOCKED} state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [WW-1:0] wcnt_q, wcnt_d;
   logic [SW-1:0] scnt_q, scnt_d;
   logic [IW-1:0] icnt_q, icnt_d;
   logic          bitslip_q, bitslip_d, aligned_q, aligned_d, lock_lost_q, lock_lost_d;
   logic          de_q, de_d, c0_q, c0_d, c1_q, c1_d;
   logic [7:0]    dout_q, dout_d, q, x, d;
   logic          tkn;
   logic [1:0]    tkn_c;

   // token detection, data decode, next-state and next-output logic
   always_comb begin
      tkn         = din == 10'h354 || din == 10'h0AB || din == 10'h154 || din == 10'h2AB;
      tkn_c       = {din == 10'h154 || din == 10'h2AB, din == 10'h0AB || din == 10'h2AB};
      q           = din[9] ? ~din[7:0] : din[7:0];
      x           = q ^ {q[6:0], 1'b0};
      d           = din[8] ? {x[7:1], q[0]} : {~x[7:1], q[0]};
      state_d     = state_q;
      tcnt_d      = tcnt_q;
      wcnt_d      = wcnt_q;
      scnt_d      = scnt_q;
      icnt_d      = icnt_q;
      bitslip_d   = 1'b0;
      lock_lost_d = 1'b0;
      case (state_q)
         ST_SEARCH: begin
            tcnt_d = tkn ? tcnt_q + 1'b1 : '0;
            wcnt_d = wcnt_q + 1'b1;
            if (tkn && tcnt_q == TW'(CTKN_CNT - 1)) begin
               state_d = ST_LOCKED;
               tcnt_d  = '0;
               wcnt_d  = '0;
               icnt_d  = '0;
            end else if (wcnt_q == WW'(SEARCH_WIN - 1)) begin
               state_d   = ST_SLIP_WAIT;
               bitslip_d = 1'b1;
               tcnt_d    = '0;
               wcnt_d    = '0;
               scnt_d    = '0;
            end
         end
         ST_SLIP_WAIT: begin
            scnt_d = scnt_q + 1'b1;
            if (scnt_q == SW'(SLIP_WAIT - 1)) begin
               state_d = ST_SEARCH;
               scnt_d  = '0;
            end
         end
         ST_LOCKED: begin
            icnt_d = tkn ? '0 : icnt_q + 1'b1;
            if (!tkn && icnt_q == IW'(LOCK_TIMEOUT - 1)) begin
               state_d     = ST_SEARCH;
               lock_lost_d = 1'b1;
               icnt_d      = '0;
            end
         end
         default: state_d = ST_SEARCH;
      endcase
      aligned_d    = state_d == ST_LOCKED;
      de_d         = aligned_d && !tkn;
      dout_d       = de_d ? d : 8'h00;
      {c1_d, c0_d} = aligned_d && tkn ? tkn_c : {c1_q, c0_q};
   end

   // state, counters and registered outputs
   always_ff @(posedge clkin or negedge rstin) begin
      if (!rstin) begin
         state_q     <= ST_SEARCH;
         tcnt_q      <= '0;
         wcnt_q      <= '0;
         scnt_q      <= '0;
         icnt_q      <= '0;
         bitslip_q   <= 1'b0;
         aligned_q   <= 1'b0;
         lock_lost_q <= 1'b0;
         dout_q      <= 8'h00;
         de_q        <= 1'b0;
         c0_q        <= 1'b0;
         c1_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         tcnt_q      <= tcnt_d;
         wcnt_q      <= wcnt_d;
         scnt_q      <= scnt_d;
         icnt_q      <= icnt_d;
         bitslip_q   <= bitslip_d;
         aligned_q   <= aligned_d;
         lock_lost_q <= lock_lost_d;
         dout_q      <= dout_d;
         de_q        <= de_d;
         c0_q        <= c0_d;
         c1_q        <= c1_d;
      end
   end

   assign bitslip   = bitslip_q;
   assign aligned   = aligned_q;
   assign lock_lost = lock_lost_q;
   assign dout      = dout_q;
   assign de        = de_q;
   assign c0        = c0_q;
   assign c1        = c1_q;
endmodule
